// File: rtl/arm_pkg.sv
// Shared encodings for the single-cycle ARM-subset core: opcode classes,
// data-processing commands, condition codes and ALU control.
package arm_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_ctrl_t;

  // nzcv packed as {N,Z,C,V}; code 1111 never passes
  function automatic logic cond_pass(input cond_e cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_core.sv
// Single-cycle ARM-subset core: decode, condition check, ALU, register file,
// flags and PC update. Memories live outside.
module arm_core
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] readdata,
  output logic [29:0] iaddr,
  output logic [31:0] aluresult,
  output logic [31:0] writedata,
  output logic        memwrite
);

  logic [31:0] pc, pc4, pc8, pcnext;
  logic [31:0] rf [0:14];
  logic [3:0]  nzcv;
  logic [1:0]  op;
  logic [3:0]  cmd, rn, rd, rm;
  logic [31:0] srca, rmval, rdval, srcb, bx, sum, result, wdata;
  logic        cout, ovf, condok, dp_ok, is_sub, is_logic;
  logic        regwrite, flagwrite, branch;
  alu_ctrl_t   alu_ctrl;

  assign op  = instr[27:26];
  assign cmd = instr[24:21];
  assign rn  = instr[19:16];
  assign rd  = instr[15:12];
  assign rm  = instr[3:0];
  assign pc4 = pc + 32'd4;
  assign pc8 = pc + 32'd8;

  // R15 reads as PC+8
  always_comb begin
    srca  = (rn == 4'd15) ? pc8 : rf[rn];
    rmval = (rm == 4'd15) ? pc8 : rf[rm];
    rdval = (rd == 4'd15) ? pc8 : rf[rd];
  end

  always_comb begin
    srcb = {20'd0, instr[11:0]};
    if (op == OP_DP) srcb = instr[25] ? {24'd0, instr[7:0]} : rmval;
  end

  always_comb begin
    alu_ctrl = ALU_ADD;
    dp_ok    = 1'b0;
    if (op == OP_DP) begin
      dp_ok = 1'b1;
      case (cmd)
        CMD_ADD: alu_ctrl = ALU_ADD;
        CMD_SUB: alu_ctrl = ALU_SUB;
        CMD_AND: alu_ctrl = ALU_AND;
        CMD_ORR: alu_ctrl = ALU_ORR;
        default: dp_ok = 1'b0;
      endcase
    end
  end

  assign is_sub       = (alu_ctrl == ALU_SUB);
  assign is_logic     = (alu_ctrl == ALU_AND) || (alu_ctrl == ALU_ORR);
  assign bx           = is_sub ? ~srcb : srcb;
  assign {cout, sum}  = {1'b0, srca} + {1'b0, bx} + {32'd0, is_sub};
  assign ovf          = (srca[31] == bx[31]) && (sum[31] != srca[31]);

  always_comb begin
    case (alu_ctrl)
      ALU_AND: result = srca & srcb;
      ALU_ORR: result = srca | srcb;
      default: result = sum;
    endcase
  end

  assign condok    = cond_pass(cond_e'(instr[31:28]), nzcv);
  assign regwrite  = condok && (dp_ok || (op == OP_MEM && instr[20]));
  assign flagwrite = condok && dp_ok && instr[20];
  assign memwrite  = reset && condok && (op == OP_MEM) && !instr[20];
  assign branch    = condok && (op == OP_BR);
  assign wdata     = (op == OP_MEM) ? readdata : result;

  always_comb begin
    pcnext = pc4;
    if (branch)                         pcnext = pc8 + {{6{instr[23]}}, instr[23:0], 2'b00};
    else if (regwrite && rd == 4'd15)   pcnext = wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc   <= '0;
      nzcv <= '0;
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      pc <= pcnext;
      if (flagwrite) nzcv <= {result[31], result == 32'd0, is_logic ? 2'b00 : {cout, ovf}};
      if (regwrite && rd != 4'd15) rf[rd] <= wdata;
    end
  end

  assign iaddr     = pc[31:2];
  assign aluresult = result;
  assign writedata = rdval;

endmodule

// File: rtl/arm_single_cycle_top.sv
// Single-cycle ARM-subset system: core plus instruction ROM and data RAM,
// with the data bus exposed so stores can be observed.
module arm_single_cycle_top
  import arm_pkg::*;
#(
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "memfile.dat"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] WriteData,
  output logic [31:0] DataAdr,
  output logic        MemWrite
);

  localparam int IW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [31:0]   imem [0:IMEM_DEPTH-1];
  logic [31:0]   dmem [0:DMEM_DEPTH-1];
  logic [29:0]   iaddr;
  logic [31:0]   instr, readdata;
  logic [IW-1:0] iidx;
  logic [DW-1:0] didx;

  // word indices wrap modulo depth; byte offset ignored
  assign iidx     = IW'(iaddr % 30'(IMEM_DEPTH));
  assign didx     = DW'(DataAdr[31:2] % 30'(DMEM_DEPTH));
  assign instr    = imem[iidx];
  assign readdata = dmem[didx];

  always_ff @(posedge clk) begin
    if (MemWrite) dmem[didx] <= WriteData;
  end

  arm_core u_core (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .readdata  (readdata),
    .iaddr     (iaddr),
    .aluresult (DataAdr),
    .writedata (WriteData),
    .memwrite  (MemWrite)
  );

endmodule

// File: tb/tb_arm_single_cycle_top.sv
// Directed bench: small hand-assembled programs, per-cycle expected bus
// activity queued up front and checked one entry per clock.
module tb_arm_single_cycle_top;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] WriteData, DataAdr;
  logic        MemWrite;

  int nassert = 0;
  int nfail   = 0;

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    string       tag;
  } exp_t;
  exp_t sb[$];

  localparam logic [3:0]  AL = 4'hE, EQ = 4'h0, NE = 4'h1, CS = 4'h2, MI = 4'h4;
  localparam logic [3:0]  C_ADD = 4'b0100, C_SUB = 4'b0010, C_AND = 4'b0000, C_ORR = 4'b1100;
  localparam logic [31:0] NOP = 32'hEC00_0000;

  arm_single_cycle_top #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .IMEM_FILE("")) dut (
    .clk       (clk),
    .reset     (reset),
    .WriteData (WriteData),
    .DataAdr   (DataAdr),
    .MemWrite  (MemWrite)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dp(input logic [3:0] cond, input logic i, input logic [3:0] cmd,
                                     input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] op2);
    return {cond, 2'b00, i, cmd, s, rn, rd, op2};
  endfunction

  // offset-mode, up, word, no writeback
  function automatic logic [31:0] mem(input logic [3:0] cond, input logic l, input logic [3:0] rn,
                                      input logic [3:0] rd, input logic [11:0] imm12);
    return {cond, 2'b01, 5'b01100, l, rn, rd, imm12};
  endfunction

  function automatic logic [31:0] br(input logic [3:0] cond, input logic [23:0] off);
    return {cond, 4'b1010, off};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] prog[$]);
    for (int i = 0; i < 64; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : NOP;
  endtask

  task automatic st(input logic [31:0] adr, input logic [31:0] wd, input string tag);
    exp_t e;
    e = '{1'b1, adr, wd, tag};
    sb.push_back(e);
  endtask

  task automatic idle(input string tag);
    exp_t e;
    e = '{1'b0, 32'd0, 32'd0, tag};
    sb.push_back(e);
  endtask

  // called at a negedge; one queue entry per executed instruction
  task automatic run();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      #1;
      chk({e.tag, ".mw"}, {31'd0, MemWrite}, {31'd0, e.mw});
      if (e.mw) begin
        chk({e.tag, ".adr"}, DataAdr, e.adr);
        chk({e.tag, ".wd"}, WriteData, e.wd);
      end
      @(negedge clk);
    end
  endtask

  task automatic restart(input logic [31:0] prog[$]);
    reset = 1'b0;
    load(prog);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] p[$];

    // reset held two edges with a STR R15,[R0,#4] at PC 0
    reset = 1'b0;
    p = '{mem(AL, 1'b0, 4'd0, 4'd15, 12'd4), NOP};
    load(p);
    @(negedge clk);
    chk("rst1.mw", {31'd0, MemWrite}, 32'd0);
    chk("rst1.pc", dut.u_core.pc, 32'd0);
    @(negedge clk);
    chk("rst2.mw", {31'd0, MemWrite}, 32'd0);
    chk("rst2.pc", dut.u_core.pc, 32'd0);
    reset = 1'b1;
    st(32'd4, 32'd8, "t1_str");
    idle("t1_nop");
    run();

    // store basics
    p = '{dp(AL, 1'b0, C_SUB, 1'b0, 4'd15, 4'd0, 12'h00F),
          dp(AL, 1'b1, C_ADD, 1'b0, 4'd0, 4'd2, 12'd5),
          dp(AL, 1'b1, C_ADD, 1'b0, 4'd0, 4'd3, 12'd12),
          mem(AL, 1'b0, 4'd0, 4'd3, 12'd100)};
    restart(p);
    idle("t2_sub"); idle("t2_add5"); idle("t2_add12");
    st(32'd100, 32'd12, "t2_str");
    run();

    // flags, conditional stores, logic ops, register operand, wrap
    p = '{dp(AL, 1'b1, C_ADD, 1'b0, 4'd0, 4'd2, 12'd5),
          dp(AL, 1'b0, C_SUB, 1'b1, 4'd2, 4'd1, 12'd2),
          mem(EQ, 1'b0, 4'd0, 4'd2, 12'd84),
          mem(NE, 1'b0, 4'd0, 4'd2, 12'd88),
          mem(CS, 1'b0, 4'd0, 4'd2, 12'd60),
          dp(AL, 1'b1, C_SUB, 1'b1, 4'd2, 4'd1, 12'd3),
          mem(EQ, 1'b0, 4'd0, 4'd2, 12'd92),
          mem(NE, 1'b0, 4'd0, 4'd1, 12'd96),
          dp(AL, 1'b1, C_ADD, 1'b1, 4'd2, 4'd1, 12'd0),
          mem(CS, 1'b0, 4'd0, 4'd2, 12'd60),
          dp(AL, 1'b1, C_ORR, 1'b0, 4'd2, 4'd5, 12'h030),
          mem(AL, 1'b0, 4'd0, 4'd5, 12'd4),
          dp(AL, 1'b1, C_AND, 1'b0, 4'd5, 4'd6, 12'h01C),
          mem(AL, 1'b0, 4'd0, 4'd6, 12'd8),
          dp(AL, 1'b0, C_ADD, 1'b0, 4'd5, 4'd7, 12'h006),
          mem(AL, 1'b0, 4'd0, 4'd7, 12'd12),
          dp(AL, 1'b1, C_SUB, 1'b1, 4'd0, 4'd1, 12'd1),
          mem(MI, 1'b0, 4'd0, 4'd1, 12'd64)};
    restart(p);
    idle("t3_add"); idle("t3_subs_z");
    st(32'd84, 32'd5, "t3_streq");
    idle("t3_strne_skip");
    st(32'd60, 32'd5, "t3_strcs");
    idle("t3_subs_nz"); idle("t3_streq_skip");
    st(32'd96, 32'd2, "t3_strne");
    idle("t3_adds"); idle("t3_strcs_skip");
    idle("t3_orr");
    st(32'd4, 32'h35, "t3_str_orr");
    idle("t3_and");
    st(32'd8, 32'h14, "t3_str_and");
    idle("t3_add_reg");
    st(32'd12, 32'h49, "t3_str_addreg");
    idle("t3_subs_neg");
    st(32'd64, 32'hFFFF_FFFF, "t3_strmi");
    run();

    // branch over an ADD, then mid-run reset replays it
    p = '{mem(AL, 1'b0, 4'd0, 4'd7, 12'd96),
          dp(AL, 1'b1, C_ADD, 1'b0, 4'd0, 4'd7, 12'd7),
          br(AL, 24'd0),
          dp(AL, 1'b1, C_ADD, 1'b0, 4'd0, 4'd7, 12'd1),
          mem(AL, 1'b0, 4'd0, 4'd7, 12'd100)};
    restart(p);
    st(32'd96, 32'd0, "t4_str_r7");
    idle("t4_add7"); idle("t4_b");
    st(32'd100, 32'd7, "t4_str");
    idle("t4_nop");
    run();

    restart(p);
    st(32'd96, 32'd0, "t6_pre_str_r7");
    idle("t6_pre_add7"); idle("t6_pre_b");
    run();
    reset = 1'b0;
    #1;
    chk("t6_rst_suppress.mw", {31'd0, MemWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    st(32'd96, 32'd0, "t6_str_r7");
    idle("t6_add7"); idle("t6_b");
    st(32'd100, 32'd7, "t6_str");
    run();

    // load round trip and data-memory wrap
    p = '{dp(AL, 1'b1, C_ADD, 1'b0, 4'd0, 4'd3, 12'd12),
          mem(AL, 1'b0, 4'd0, 4'd3, 12'd40),
          mem(AL, 1'b1, 4'd0, 4'd4, 12'd40),
          mem(AL, 1'b0, 4'd0, 4'd4, 12'd44),
          dp(AL, 1'b1, C_ADD, 1'b0, 4'd0, 4'd8, 12'd99),
          mem(AL, 1'b0, 4'd0, 4'd8, 12'd296),
          mem(AL, 1'b1, 4'd0, 4'd9, 12'd40),
          mem(AL, 1'b0, 4'd0, 4'd9, 12'd48)};
    restart(p);
    idle("t5_add");
    st(32'd40, 32'd12, "t5_str1");
    idle("t5_ldr");
    st(32'd44, 32'd12, "t5_str2");
    idle("t5_add99");
    st(32'd296, 32'd99, "t5_str_wrap");
    idle("t5_ldr_wrap");
    st(32'd48, 32'd99, "t5_str3");
    run();

    // write to R15 redirects the PC
    p = '{dp(AL, 1'b1, C_ADD, 1'b0, 4'd15, 4'd15, 12'd4),
          mem(AL, 1'b0, 4'd0, 4'd0, 12'd0),
          mem(AL, 1'b0, 4'd0, 4'd0, 12'd0),
          mem(AL, 1'b0, 4'd0, 4'd15, 12'd20)};
    restart(p);
    idle("t7_add_pc");
    st(32'd20, 32'd20, "t7_str_pc");
    run();

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
